// File: rtl/match_gate_sweeper_if.sv
// match_gate_sweeper_if: operand/result bundle for match_gate_sweeper; abort exists only with SWEEP_ABORT_EN
interface match_gate_sweeper_if #(parameter int W = 4);
  localparam int CNT_W = 2*W+2;
  logic mode;
  logic start;
  logic in_valid;
  logic a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] c_in;
`ifdef SWEEP_ABORT_EN
  logic abort;
`endif
  logic [W-1:0] x_out;
  logic all_match;
  logic out_valid;
  logic busy;
  logic done;
  logic [CNT_W-1:0] match_count;
`ifdef SWEEP_ABORT_EN
  modport master(output mode, start, in_valid, a_in, b_in, c_in, abort,
                 input x_out, all_match, out_valid, busy, done, match_count);
  modport slave(input mode, start, in_valid, a_in, b_in, c_in, abort,
                output x_out, all_match, out_valid, busy, done, match_count);
`else
  modport master(output mode, start, in_valid, a_in, b_in, c_in,
                 input x_out, all_match, out_valid, busy, done, match_count);
  modport slave(input mode, start, in_valid, a_in, b_in, c_in,
                output x_out, all_match, out_valid, busy, done, match_count);
`endif
endinterface

// File: rtl/match_gate_sweeper.sv
// match_gate_sweeper: registered x = a & ~(b^c) per bit, direct or exhaustive sweep; SWEEP_ABORT_EN adds sweep abort
module match_gate_sweeper #(parameter int W = 4) (
  input logic clk,
  input logic rst,
  match_gate_sweeper_if.slave bus
);
  localparam int VW = 2*W+1;
  localparam int CNT_W = 2*W+2;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_n;
  logic [VW-1:0] v, v_n;
  logic [W-1:0] f_in, f_v, x_n;
  logic [CNT_W-1:0] cnt_n;
  logic am_n, ov_n, busy_n, done_n, stop;
  assign f_in = {W{bus.a_in}} & ~(bus.b_in ^ bus.c_in);
  assign f_v = {W{v[2*W]}} & ~(v[2*W-1:W] ^ v[W-1:0]);
`ifdef SWEEP_ABORT_EN
  assign stop = bus.abort;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_n = state;
    v_n = v;
    x_n = bus.x_out;
    am_n = bus.all_match;
    ov_n = 1'b0;
    busy_n = bus.busy;
    done_n = 1'b0;
    cnt_n = bus.match_count;
    if (state == IDLE) begin
      if (bus.mode && bus.start) begin
        state_n = SWEEP;
        v_n = '0;
        cnt_n = '0;
        busy_n = 1'b1;
      end else if (!bus.mode && bus.in_valid) begin
        x_n = f_in;
        am_n = &f_in;
        ov_n = 1'b1;
      end
    end else if (stop) begin
      state_n = IDLE;
      v_n = '0;
      busy_n = 1'b0;
    end else begin
      x_n = f_v;
      am_n = &f_v;
      ov_n = 1'b1;
      cnt_n = bus.match_count + CNT_W'(&f_v);
      v_n = v + 1'b1;
      done_n = &v;
      busy_n = ~&v;
      state_n = (&v) ? IDLE : SWEEP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      v <= '0;
      bus.x_out <= '0;
      bus.all_match <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.match_count <= '0;
    end else begin
      state <= state_n;
      v <= v_n;
      bus.x_out <= x_n;
      bus.all_match <= am_n;
      bus.out_valid <= ov_n;
      bus.busy <= busy_n;
      bus.done <= done_n;
      bus.match_count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_match_gate_sweeper.sv
// tb_match_gate_sweeper: randomized self-checking bench for W=4 and W=1 instances against a bitwise reference model
module tb_match_gate_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  match_gate_sweeper_if #(.W(4)) bus4();
  match_gate_sweeper_if #(.W(1)) bus1();
  match_gate_sweeper #(.W(4)) dut4(.clk(clk), .rst(rst), .bus(bus4.slave));
  match_gate_sweeper #(.W(1)) dut1(.clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [3:0] ref4(input int a, input int b, input int c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (a != 0) && (((b >> i) & 1) == ((c >> i) & 1));
    return r;
  endfunction

  task automatic drive_idle();
    bus4.mode = 0; bus4.start = 0; bus4.in_valid = 0; bus4.a_in = 0; bus4.b_in = 0; bus4.c_in = 0;
    bus1.mode = 0; bus1.start = 0; bus1.in_valid = 0; bus1.a_in = 0; bus1.b_in = 0; bus1.c_in = 0;
`ifdef SWEEP_ABORT_EN
    bus4.abort = 0; bus1.abort = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus4.x_out, bus4.all_match, bus4.out_valid, bus4.busy, bus4.done, bus4.match_count} !== '0) begin
        fails++; $display("FAIL reset4 phase %0d got x=%h am=%b ov=%b busy=%b done=%b cnt=%0d want all 0", k,
          bus4.x_out, bus4.all_match, bus4.out_valid, bus4.busy, bus4.done, bus4.match_count);
      end
      checks++;
      if ({bus1.x_out, bus1.all_match, bus1.out_valid, bus1.busy, bus1.done, bus1.match_count} !== '0) begin
        fails++; $display("FAIL reset1 phase %0d got x=%h am=%b ov=%b busy=%b done=%b cnt=%0d want all 0", k,
          bus1.x_out, bus1.all_match, bus1.out_valid, bus1.busy, bus1.done, bus1.match_count);
      end
      rst = 0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_direct();
    int a, b, c;
    logic [3:0] exp;
    logic [9:0] cnt0;
    cnt0 = bus4.match_count;
    for (int k = 0; k < 24; k++) begin
      a = (k < 2) ? 1 : (k == 2) ? 0 : int'($urandom_range(0, 1));
      b = (k < 2) ? 'hA : (k == 2) ? 'h6 : int'($urandom_range(0, 15));
      c = (k == 0) ? 'hA : (k == 1) ? 'h5 : (k == 2) ? 'h6 :
          ($urandom_range(0, 2) == 0) ? b : int'($urandom_range(0, 15));
      bus4.mode = 0; bus4.in_valid = 1; bus4.a_in = a[0]; bus4.b_in = b[3:0]; bus4.c_in = c[3:0];
      @(negedge clk);
      exp = ref4(a, b, c);
      checks++;
      if (bus4.x_out !== exp) begin fails++; $display("FAIL direct_x k=%0d got %h want %h", k, bus4.x_out, exp); end
      checks++;
      if (bus4.all_match !== (a == 1 && b == c)) begin
        fails++; $display("FAIL direct_all_match k=%0d got %b want %b", k, bus4.all_match, (a == 1 && b == c));
      end
      checks++;
      if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL direct_out_valid k=%0d got %b want 1", k, bus4.out_valid); end
      checks++;
      if (bus4.match_count !== cnt0) begin fails++; $display("FAIL direct_count k=%0d got %0d want %0d", k, bus4.match_count, cnt0); end
    end
    bus4.in_valid = 0;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.x_out !== exp) begin
      fails++; $display("FAIL direct_idle got ov=%b x=%h want ov=0 x=%h", bus4.out_valid, bus4.x_out, exp);
    end
    bus4.mode = 1; bus4.in_valid = 1;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      fails++; $display("FAIL mode1_no_start got ov=%b busy=%b want 0 0", bus4.out_valid, bus4.busy);
    end
    drive_idle();
  endtask

  task automatic sweep4(input int n, output int hits);
    int a, b, c;
    logic [3:0] exp;
    hits = 0;
    bus4.mode = 1; bus4.start = 1; bus4.in_valid = 1;
    @(negedge clk);
    checks++;
    if (bus4.busy !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.match_count !== 0) begin
      fails++; $display("FAIL sweep_start got busy=%b ov=%b cnt=%0d want 1 0 0", bus4.busy, bus4.out_valid, bus4.match_count);
    end
    for (int i = 0; i < n; i++) begin
      bus4.start = 1'($urandom_range(0, 1)); bus4.in_valid = 1'($urandom_range(0, 1));
      bus4.mode = 1'($urandom_range(0, 1)); bus4.a_in = 1'($urandom_range(0, 1));
      bus4.b_in = 4'($urandom_range(0, 15)); bus4.c_in = 4'($urandom_range(0, 15));
      @(negedge clk);
      a = (i >> 8) & 1; b = (i >> 4) & 15; c = i & 15;
      exp = ref4(a, b, c);
      if (a == 1 && b == c) hits++;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.x_out !== exp) begin
        fails++; $display("FAIL sweep_result i=%0d got ov=%b x=%h want ov=1 x=%h", i, bus4.out_valid, bus4.x_out, exp);
      end
      checks++;
      if (bus4.all_match !== (a == 1 && b == c) || bus4.match_count !== hits) begin
        fails++; $display("FAIL sweep_match i=%0d got am=%b cnt=%0d want am=%b cnt=%0d", i,
          bus4.all_match, bus4.match_count, (a == 1 && b == c), hits);
      end
      checks++;
      if (bus4.done !== (i == 511) || bus4.busy !== (i != 511)) begin
        fails++; $display("FAIL sweep_flags i=%0d got done=%b busy=%b want done=%b busy=%b", i,
          bus4.done, bus4.busy, (i == 511), (i != 511));
      end
    end
    drive_idle();
  endtask

  task automatic test_full_sweep();
    int h;
    sweep4(512, h);
    checks++;
    if (bus4.match_count !== 16) begin fails++; $display("FAIL sweep_final_count got %0d want 16", bus4.match_count); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus4.out_valid !== 0 || bus4.done !== 0 || bus4.busy !== 0 || bus4.match_count !== 16) begin
      fails++; $display("FAIL sweep_after got ov=%b done=%b busy=%b cnt=%0d want 0 0 0 16",
        bus4.out_valid, bus4.done, bus4.busy, bus4.match_count);
    end
  endtask

  task automatic test_sweep_w1();
    int a, b, c, hits;
    hits = 0;
    bus1.mode = 1; bus1.start = 1;
    @(negedge clk);
    bus1.start = 0;
    checks++;
    if (bus1.busy !== 1'b1 || bus1.out_valid !== 1'b0) begin
      fails++; $display("FAIL w1_start got busy=%b ov=%b want 1 0", bus1.busy, bus1.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = (i >> 2) & 1; b = (i >> 1) & 1; c = i & 1;
      if (a == 1 && b == c) hits++;
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.x_out !== (a == 1 && b == c) || bus1.all_match !== (a == 1 && b == c)) begin
        fails++; $display("FAIL w1_result i=%0d got ov=%b x=%b am=%b want 1 %b %b", i,
          bus1.out_valid, bus1.x_out, bus1.all_match, (a == 1 && b == c), (a == 1 && b == c));
      end
      checks++;
      if (bus1.done !== (i == 7) || bus1.match_count !== hits) begin
        fails++; $display("FAIL w1_flags i=%0d got done=%b cnt=%0d want %b %0d", i, bus1.done, bus1.match_count, (i == 7), hits);
      end
    end
    checks++;
    if (bus1.match_count !== 2) begin fails++; $display("FAIL w1_count got %0d want 2", bus1.match_count); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int h;
    sweep4(100, h);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus4.x_out, bus4.all_match, bus4.out_valid, bus4.busy, bus4.done, bus4.match_count} !== '0) begin
        fails++; $display("FAIL reset_mid k=%0d got x=%h am=%b ov=%b busy=%b done=%b cnt=%0d want all 0", k,
          bus4.x_out, bus4.all_match, bus4.out_valid, bus4.busy, bus4.done, bus4.match_count);
      end
      @(negedge clk);
    end
    test_full_sweep();
  endtask

`ifdef SWEEP_ABORT_EN
  task automatic test_abort();
    int h;
    for (int n = 300; n <= 511; n += 211) begin
      sweep4(n, h);
      bus4.abort = 1;
      @(negedge clk);
      bus4.abort = 0;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (bus4.busy !== 0 || bus4.out_valid !== 0 || bus4.done !== 0 || bus4.match_count !== h) begin
          fails++; $display("FAIL abort n=%0d k=%0d got busy=%b ov=%b done=%b cnt=%0d want 0 0 0 %0d", n, k,
            bus4.busy, bus4.out_valid, bus4.done, bus4.match_count, h);
        end
        @(negedge clk);
      end
    end
    bus4.abort = 1;
    @(negedge clk);
    bus4.abort = 0;
    checks++;
    if (bus4.busy !== 0 || bus4.match_count !== h) begin
      fails++; $display("FAIL abort_idle got busy=%b cnt=%0d want 0 %0d", bus4.busy, bus4.match_count, h);
    end
    test_full_sweep();
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_direct();
    test_sweep_w1();
    test_reset_mid();
`ifdef SWEEP_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
